// File: rtl/scan_decoder_if.sv
// Handshake bundle for scan_decoder: control/select inputs and one-hot/status outputs.
// The decoder attaches through the slave modport and the controlling logic through master.
interface scan_decoder_if #(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned DIV_W = 8
);
  logic                  en;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [DIV_W-1:0]      div;
  logic                  start;
  logic                  stop;
  logic [2**SEL_W-1:0]   out;
  logic [SEL_W-1:0]      idx;
  logic                  busy;
  logic                  wrap;

  modport master (
    output en, mode, sel, div, start, stop,
    input  out, idx, busy, wrap
  );

  modport slave (
    input  en, mode, sel, div, start, stop,
    output out, idx, busy, wrap
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a scan sequencer: direct decode of sel, or an
// autonomous walk through every output position with a programmable dwell.
module scan_decoder #(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned DIV_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_decoder_if.slave bus
);
  localparam int unsigned N = 2**SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       out_q, out_d;
  logic [SEL_W-1:0]   idx_q, idx_d, idx_nxt;
  logic [DIV_W-1:0]   pre_q, pre_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    wrap_d  = 1'b0;
    idx_nxt = idx_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        out_d = '0;
        if (bus.en && !bus.mode) begin
          // Load on the entry edge so out tracks one-hot(idx) from the first DIRECT cycle.
          state_d = ST_DIRECT;
          out_d   = onehot(bus.sel);
          idx_d   = bus.sel;
        end else if (bus.en && bus.mode && bus.start && !bus.stop) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          pre_d   = '0;
          out_d   = onehot({SEL_W{1'b0}});
        end
      end

      ST_DIRECT: begin
        if (!bus.en || bus.mode) begin
          state_d = ST_IDLE;
          out_d   = '0;
        end else begin
          out_d = onehot(bus.sel);
          idx_d = bus.sel;
        end
      end

      ST_SCAN: begin
        if (bus.stop || !bus.en || !bus.mode) begin
          state_d = ST_IDLE;
          out_d   = '0;
          idx_d   = '0;
          pre_d   = '0;
        end else if (pre_q >= bus.div) begin
          // >= rather than == so a live drop of div below the count advances at once.
          pre_d  = '0;
          idx_d  = idx_nxt;
          out_d  = onehot(idx_nxt);
          wrap_d = (idx_q == {SEL_W{1'b1}});
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        out_d   = '0;
        idx_d   = '0;
        pre_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      idx_q   <= '0;
      pre_q   <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.busy = busy_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: a 16-output instance and an 8-output instance
// sharing clock and reset, with expected values worked out independently of the RTL.
module tb_scan_decoder;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  scan_decoder_if #(.SEL_W(4), .DIV_W(8)) b4 ();
  scan_decoder_if #(.SEL_W(3), .DIV_W(4)) b3 ();

  scan_decoder #(.SEL_W(4), .DIV_W(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.slave)
  );

  scan_decoder #(.SEL_W(3), .DIV_W(4)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [15:0] e_out, input logic [3:0] e_idx,
                      input logic e_busy, input logic e_wrap);
    chk({tag, ".out"},  32'(b4.out),  32'(e_out));
    chk({tag, ".idx"},  32'(b4.idx),  32'(e_idx));
    chk({tag, ".busy"}, 32'(b4.busy), 32'(e_busy));
    chk({tag, ".wrap"}, 32'(b4.wrap), 32'(e_wrap));
  endtask

  initial begin
    int          e_idx;
    logic [7:0]  ref8;
    logic [2:0]  s3;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    b4.en = 1'b0; b4.mode = 1'b0; b4.sel = '0; b4.div = '0; b4.start = 1'b0; b4.stop = 1'b0;
    b3.en = 1'b0; b3.mode = 1'b0; b3.sel = '0; b3.div = '0; b3.start = 1'b0; b3.stop = 1'b0;

    tick(); tick();
    chk4("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Direct decode
    b4.en = 1'b1; b4.mode = 1'b0; b4.sel = 4'hA;
    tick();
    chk4("direct_A", 16'h0400, 4'd10, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1 chk4("async_rst", 16'h0000, 4'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    chk4("direct_reentry", 16'h0400, 4'd10, 1'b0, 1'b0);
    b4.sel = 4'h0;
    tick();
    chk4("direct_0", 16'h0001, 4'd0, 1'b0, 1'b0);
    b4.sel = 4'hF;
    tick();
    chk4("direct_F", 16'h8000, 4'd15, 1'b0, 1'b0);

    // Leaving DIRECT via mode: out clears, idx keeps last value
    b4.mode = 1'b1;
    tick();
    chk4("direct_exit", 16'h0000, 4'd15, 1'b0, 1'b0);

    // Scan with div=0, three sweeps
    b4.div = 8'd0; b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    chk4("scan0_start", 16'h0001, 4'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 48; k++) begin
      tick();
      e_idx = k % 16;
      chk4($sformatf("scan0_k%0d", k), 16'(1) << e_idx, 4'(e_idx), 1'b1, (e_idx == 0));
    end
    b4.stop = 1'b1;
    tick();
    b4.stop = 1'b0;
    chk4("scan0_stop", 16'h0000, 4'd0, 1'b0, 1'b0);

    // Scan with div=2: each position held three cycles
    b4.div = 8'd2; b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    chk4("scan2_start", 16'h0001, 4'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 48; k++) begin
      tick();
      e_idx = (k / 3) % 16;
      chk4($sformatf("scan2_k%0d", k), 16'(1) << e_idx, 4'(e_idx), 1'b1, (k == 48));
    end
    // Prescaler now 1 at position 0; with div=2 this would hold, so div=0 must advance
    tick();
    chk4("div_hold", 16'h0001, 4'd0, 1'b1, 1'b0);
    b4.div = 8'd0;
    tick();
    chk4("div_drop", 16'h0002, 4'd1, 1'b1, 1'b0);
    tick();
    chk4("div_fast2", 16'h0004, 4'd2, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk4("at_idx5", 16'h0020, 4'd5, 1'b1, 1'b0);

    // Abort by stop at idx 5
    b4.stop = 1'b1;
    tick();
    b4.stop = 1'b0;
    chk4("abort_stop", 16'h0000, 4'd0, 1'b0, 1'b0);

    // Earliest re-entry, then abort by en low
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    chk4("reenter", 16'h0001, 4'd0, 1'b1, 1'b0);
    repeat (5) tick();
    chk4("en_at5", 16'h0020, 4'd5, 1'b1, 1'b0);
    b4.en = 1'b0;
    tick();
    chk4("abort_en", 16'h0000, 4'd0, 1'b0, 1'b0);
    b4.en = 1'b1;
    tick();
    chk4("idle_no_start", 16'h0000, 4'd0, 1'b0, 1'b0);

    // Abort by mode going to direct
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    repeat (5) tick();
    chk4("mode_at5", 16'h0020, 4'd5, 1'b1, 1'b0);
    b4.mode = 1'b0;
    tick();
    chk4("abort_mode", 16'h0000, 4'd0, 1'b0, 1'b0);
    b4.en = 1'b0; b4.mode = 1'b1;
    tick();
    b4.en = 1'b1;

    // start and stop together in IDLE: stop wins
    b4.start = 1'b1; b4.stop = 1'b1;
    tick();
    chk4("start_stop1", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick();
    chk4("start_stop2", 16'h0000, 4'd0, 1'b0, 1'b0);
    b4.start = 1'b0; b4.stop = 1'b0;

    // Reset mid-scan at idx 7
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    repeat (7) tick();
    chk4("rst_at7", 16'h0080, 4'd7, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk4("rst_mid_scan", 16'h0000, 4'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk4("post_rst_idle", 16'h0000, 4'd0, 1'b0, 1'b0);
    b4.en = 1'b0;

    // 8-output instance: scan with div=1, two sweeps
    b3.en = 1'b1; b3.mode = 1'b1; b3.div = 4'd1; b3.start = 1'b1;
    tick();
    b3.start = 1'b0;
    chk("p3_start.out", 32'(b3.out), 32'h01);
    chk("p3_start.busy", 32'(b3.busy), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      e_idx = (k / 2) % 8;
      chk($sformatf("p3_k%0d.out", k), 32'(b3.out), 32'(1) << e_idx);
      chk($sformatf("p3_k%0d.wrap", k), 32'(b3.wrap), 32'(k % 16 == 0));
    end
    b3.stop = 1'b1;
    tick();
    b3.stop = 1'b0;
    chk("p3_stop.out", 32'(b3.out), 32'h00);
    chk("p3_stop.busy", 32'(b3.busy), 32'd0);

    // 8-output instance: random direct selects against a reference one-hot
    b3.mode = 1'b0;
    for (int k = 0; k < 12; k++) begin
      s3 = 3'($urandom_range(0, 7));
      b3.sel = s3;
      tick();
      ref8 = 8'h00;
      for (int unsigned b = 0; b < 8; b++) if (b == 32'(s3)) ref8[b] = 1'b1;
      chk($sformatf("p3_dir%0d.out", k), 32'(b3.out), 32'(ref8));
      chk($sformatf("p3_dir%0d.idx", k), 32'(b3.idx), 32'(s3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
